axis_histogram_accumulator: RTL and testbench
=============================================

// Module: axis_histogram_accumulator
// PURPOSE
// - Upstream feeder of the USB controller: bins detector events by x/y position into 128-bin, 16-bit count histograms.
// - Integrates over a programmable window, then hands the frozen frame off via start_sending/read_index.
// - Ping-pong banks keep accumulation running while the previous frame is read out and cleared.
// PARAMETERS
// - NBINS        128   bins per axis; fixed by the controller's 7-bit read index
// - CNT_W        16    count width; matches controller data width
// - ARM_TIMEOUT  1024  cycles to wait for the controller to start reading before re-arming
// PORTS
// - clk              in   1      system clock
// - reset            in   1      synchronous, active-high
// - enable           in   1      1 = window timer runs and events are accepted
// - window_len       in   32     integration window in clk cycles; 0 treated as 1
// - ev_valid         in   1      event strobe; at most one event per cycle
// - ev_x, ev_y       in   7      event bin indices
// - read_index_yaxis in   7      controller read address, y histogram
// - read_index_xaxis in   7      controller read address, x histogram
// - data_yaxis       out  16     readout-bank y count at read_index_yaxis, combinational
// - data_xaxis       out  16     readout-bank x count at read_index_xaxis, combinational
// - start_sending    out  1      frame ready for controller capture
// - frame_count      out  16     frames handed off (wraps)
// - overrun_count    out  16     window ends lost to busy readout (saturates)
// - busy             out  1      readout FSM not in R_IDLE
// BEHAVIOUR
// - Reset: both banks all 0, bank_sel=0, timer=0, start_sending=0, counters 0, FSM R_IDLE.
// - Event with enable=1: active bank x[ev_x] and y[ev_y] each +1; read-modify-write in 1 cycle; visible next cycle.
// - Window end: timer==window_len-1 with enable=1; timer returns to 0.
//   - FSM in R_IDLE: toggle bank_sel; old bank becomes readout bank; FSM goes to R_ARM; frame_count+1.
//   - FSM busy: no swap; overrun_count+1; active bank keeps accumulating, so frames merge.
// - Event in the swap cycle goes to the new active bank.
// - Readout FSM:
//   - R_IDLE: start_sending=0.
//   - R_ARM: start_sending=1. read_index_yaxis==127 -> R_RUN. ARM_TIMEOUT cycles elapsed -> R_GAP.
//   - R_GAP: start_sending=0 for exactly 2 cycles -> R_ARM. The controller needs a low level to leave its wait-down state.
//   - R_RUN: start_sending=1. The cycle where read_index_yaxis==0 is the controller's last capture; next state R_CLEAR.
//   - R_CLEAR: start_sending=0; clear readout bank one bin per cycle, index 0..127 (128 cycles) -> R_IDLE.
// - The active bank is never cleared by R_CLEAR. Readout data is stable from swap until R_CLEAR.
// - Reset mid-frame: immediate return to reset state; a partial frame is discarded; start_sending=0 the next cycle.
// CONFIGURATION
// - AXIS_HIST_SATURATE_EN defined: an increment at 16'hFFFF holds at 16'hFFFF.
// - AXIS_HIST_SATURATE_EN undefined: counts wrap modulo 2^16 (FFFF+1 = 0000).
// STRUCTURE
// - Package axis_hist_pkg:
//   - NBINS, CNT_W, IDX_W=7
//   - rd_state_t {R_IDLE, R_ARM, R_GAP, R_RUN, R_CLEAR}
//   - GAP_CYCLES=2
// - Sub-module axis_hist_bank: NBINS x CNT_W register array.
//   - Ports: increment (inc_en, inc_idx), clear (clr_en, clr_idx), async read (rd_idx, rd_data).
//   - Clear has priority over increment on the same bank.
//   - Instantiated 4x: {x,y} x {bank0,bank1}.
// - Top level holds the timer, bank_sel, readout FSM, counters and output muxing.
// TESTING
// - Bench uses a cycle-accurate controller model for read_index/start_sending.
// - Single events: window_len=100; 3 events (x=5,y=9); 1 event (x=127,y=0).
//   -> after handoff: x[5]=3, x[127]=1, y[9]=3, y[0]=1, all other bins 0; frame_count=1.
// - Saturation: 70000 events at x=0.
//   -> 65535 with AXIS_HIST_SATURATE_EN; 4464 without it.
// - Busy controller: model keeps read_index at 0 for 3000 cycles after start_sending rises.
//   -> start_sending drops 2 cycles at 1024 and again at 2050 (re-arms); frame delivered exactly once with correct counts.
// - Overrun: window_len=50, readout held in R_ARM.
//   -> overrun_count increments every 50 cycles; next frame holds the merged counts; no swap until R_IDLE.
// - Swap boundary: event (x=7,y=7) on the window-end cycle.
//   -> absent from the frame being read; present (=1) in the following frame.
//   -> R_CLEAR leaves the readout bank all 0 after 128 cycles.
// - Reset asserted during R_RUN at read_index=60.
//   -> next cycle: start_sending=0, data_xaxis=data_yaxis=0 for all indices, counters 0.

Source files
------------

// File: rtl/axis_hist_pkg.sv
// rtl/axis_hist_pkg.sv - shared constants, readout states and count update for the histogram accumulator.
// AXIS_HIST_SATURATE_EN selects saturating bin counts; otherwise counts wrap.
package axis_hist_pkg;

   localparam int NBINS       = 128;
   localparam int CNT_W       = 16;
   localparam int IDX_W       = 7;
   localparam int ARM_TIMEOUT = 1024;
   localparam int GAP_CYCLES  = 2;

   typedef enum logic [2:0] {
      R_IDLE,
      R_ARM,
      R_GAP,
      R_RUN,
      R_CLEAR
   } rd_state_t;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef AXIS_HIST_SATURATE_EN
      return (v == '1) ? v : v + 1'b1;
`else
      return v + 1'b1;
`endif
   endfunction

endpackage

// File: rtl/axis_hist_bank.sv
// rtl/axis_hist_bank.sv - NBINS x CNT_W count array with single-cycle increment, clear and async read.
module axis_hist_bank
   import axis_hist_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_en,
   input  logic [IDX_W-1:0] inc_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CNT_W-1:0] rd_data
);

   logic [CNT_W-1:0] r_mem [NBINS];

   // Clear wins over increment so a bank being wiped never picks up stray counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NBINS; i++) r_mem[i] <= '0;
      end else if (clr_en) begin
         r_mem[clr_idx] <= '0;
      end else if (inc_en) begin
         r_mem[inc_idx] <= cnt_inc(r_mem[inc_idx]);
      end
   end

   assign rd_data = r_mem[rd_idx];

endmodule

// File: rtl/axis_histogram_accumulator.sv
// rtl/axis_histogram_accumulator.sv - ping-pong x/y event histograms with windowed handoff to the USB controller.
module axis_histogram_accumulator
   import axis_hist_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [31:0]      window_len,
   input  logic             ev_valid,
   input  logic [IDX_W-1:0] ev_x,
   input  logic [IDX_W-1:0] ev_y,
   input  logic [IDX_W-1:0] read_index_yaxis,
   input  logic [IDX_W-1:0] read_index_xaxis,
   output logic [CNT_W-1:0] data_yaxis,
   output logic [CNT_W-1:0] data_xaxis,
   output logic             start_sending,
   output logic [15:0]      frame_count,
   output logic [15:0]      overrun_count,
   output logic             busy
);

   logic [31:0]      r_timer;
   logic             r_bank_sel;
   rd_state_t        r_state;
   rd_state_t        w_next;
   logic [15:0]      r_cnt;
   logic [15:0]      r_frame_count;
   logic [15:0]      r_overrun_count;

   logic [31:0]      w_len_m1;
   logic             w_win_end;
   logic             w_swap;
   logic             w_ev;
   logic             w_act_sel;
   logic             w_rd_sel;
   logic             w_clr_en;
   logic             w_start;
   logic             w_busy;
   logic [IDX_W-1:0] w_clr_idx;
   logic [CNT_W-1:0] w_x0_data, w_x1_data, w_y0_data, w_y1_data;

   // >= rather than == so a window shortened mid-count still ends promptly.
   assign w_len_m1  = (window_len == 32'd0) ? 32'd0 : window_len - 32'd1;
   assign w_win_end = enable && (r_timer >= w_len_m1);
   assign w_swap    = w_win_end && (r_state == R_IDLE);
   assign w_ev      = ev_valid && enable;
   assign w_act_sel = r_bank_sel ^ w_swap;
   assign w_rd_sel  = ~r_bank_sel;
   assign w_clr_idx = r_cnt[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer         <= '0;
         r_bank_sel      <= 1'b0;
         r_frame_count   <= '0;
         r_overrun_count <= '0;
      end else begin
         if (enable) r_timer <= w_win_end ? 32'd0 : r_timer + 32'd1;
         if (w_swap) begin
            r_bank_sel    <= ~r_bank_sel;
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_win_end && (r_state != R_IDLE) && (r_overrun_count != '1))
            r_overrun_count <= r_overrun_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset || (w_next != r_state)) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 16'd1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         R_IDLE:  if (w_swap) w_next = R_ARM;
         R_ARM: begin
            if (read_index_yaxis == IDX_W'(NBINS - 1))  w_next = R_RUN;
            else if (r_cnt == 16'(ARM_TIMEOUT - 1))     w_next = R_GAP;
         end
         R_GAP:   if (r_cnt == 16'(GAP_CYCLES - 1)) w_next = R_ARM;
         // Index 0 is the controller's final capture of the frame.
         R_RUN:   if (read_index_yaxis == '0) w_next = R_CLEAR;
         R_CLEAR: if (r_cnt == 16'(NBINS - 1)) w_next = R_IDLE;
         default: w_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_start  = 1'b0;
      w_clr_en = 1'b0;
      w_busy   = (r_state != R_IDLE);
      case (r_state)
         R_ARM:   w_start  = 1'b1;
         R_RUN:   w_start  = 1'b1;
         R_CLEAR: w_clr_en = 1'b1;
         default: ;
      endcase
   end

   axis_hist_bank u_x0 (
      .clk(clk), .reset(reset),
      .inc_en(w_ev && !w_act_sel), .inc_idx(ev_x),
      .clr_en(w_clr_en && !w_rd_sel), .clr_idx(w_clr_idx),
      .rd_idx(read_index_xaxis), .rd_data(w_x0_data)
   );

   axis_hist_bank u_x1 (
      .clk(clk), .reset(reset),
      .inc_en(w_ev && w_act_sel), .inc_idx(ev_x),
      .clr_en(w_clr_en && w_rd_sel), .clr_idx(w_clr_idx),
      .rd_idx(read_index_xaxis), .rd_data(w_x1_data)
   );

   axis_hist_bank u_y0 (
      .clk(clk), .reset(reset),
      .inc_en(w_ev && !w_act_sel), .inc_idx(ev_y),
      .clr_en(w_clr_en && !w_rd_sel), .clr_idx(w_clr_idx),
      .rd_idx(read_index_yaxis), .rd_data(w_y0_data)
   );

   axis_hist_bank u_y1 (
      .clk(clk), .reset(reset),
      .inc_en(w_ev && w_act_sel), .inc_idx(ev_y),
      .clr_en(w_clr_en && w_rd_sel), .clr_idx(w_clr_idx),
      .rd_idx(read_index_yaxis), .rd_data(w_y1_data)
   );

   assign data_xaxis    = w_rd_sel ? w_x1_data : w_x0_data;
   assign data_yaxis    = w_rd_sel ? w_y1_data : w_y0_data;
   assign start_sending = w_start;
   assign busy          = w_busy;
   assign frame_count   = r_frame_count;
   assign overrun_count = r_overrun_count;

endmodule

// File: tb/tb_axis_histogram_accumulator.sv
// tb/tb_axis_histogram_accumulator.sv - directed vectors and controller-model frame checks for axis_histogram_accumulator.
module tb_axis_histogram_accumulator;
   import axis_hist_pkg::*;

`ifdef AXIS_HIST_SATURATE_EN
   localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
   localparam logic [15:0] SAT_EXP = 16'd4464;
`endif

   logic        clk = 1'b0;
   logic        reset, enable, ev_valid;
   logic [31:0] window_len;
   logic [6:0]  ev_x, ev_y, read_index_yaxis, read_index_xaxis;
   logic [15:0] data_yaxis, data_xaxis, frame_count, overrun_count;
   logic        start_sending, busy;

   always #5 clk = ~clk;

   axis_histogram_accumulator dut (
      .clk(clk), .reset(reset), .enable(enable), .window_len(window_len),
      .ev_valid(ev_valid), .ev_x(ev_x), .ev_y(ev_y),
      .read_index_yaxis(read_index_yaxis), .read_index_xaxis(read_index_xaxis),
      .data_yaxis(data_yaxis), .data_xaxis(data_xaxis),
      .start_sending(start_sending), .frame_count(frame_count),
      .overrun_count(overrun_count), .busy(busy)
   );

   typedef struct {
      logic [6:0]  rx;
      logic [6:0]  ry;
      logic [15:0] ex;
      logic [15:0] ey;
   } vec_t;

   vec_t        tbl [6];
   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] cap_x [128];
   logic [15:0] cap_y [128];
   logic [15:0] exp_x [128];
   logic [15:0] exp_y [128];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1; enable = 1'b0; ev_valid = 1'b0;
      read_index_xaxis = '0; read_index_yaxis = '0;
      tick();
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_ev(input logic [6:0] x, input logic [6:0] y);
      ev_x = x; ev_y = y; ev_valid = 1'b1;
      tick();
      ev_valid = 1'b0;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 128; i++) begin
         exp_x[i] = '0;
         exp_y[i] = '0;
      end
   endtask

   task automatic wait_start(input string name, input int limit);
      int g = 0;
      while (start_sending !== 1'b1 && g < limit) begin
         @(negedge clk);
         g++;
      end
      check({name, "_start_seen"}, 32'(g < limit), 32'd1);
   endtask

   // Controller model: waits for start_sending, walks read_index 127 down to 0.
   task automatic capture_frame(input string name);
      int lo = 0;
      wait_start(name, 3000);
      for (int i = 127; i >= 0; i--) begin
         tick();
         read_index_xaxis = 7'(i);
         read_index_yaxis = 7'(i);
         @(negedge clk);
         cap_x[i] = data_xaxis;
         cap_y[i] = data_yaxis;
         if (start_sending !== 1'b1) lo++;
      end
      check({name, "_start_held"}, lo, 0);
   endtask

   task automatic compare_frame(input string name);
      int dx = 0;
      int dy = 0;
      for (int i = 0; i < 128; i++) begin
         if (cap_x[i] !== exp_x[i]) dx++;
         if (cap_y[i] !== exp_y[i]) dy++;
      end
      check({name, "_x_bins_wrong"}, dx, 0);
      check({name, "_y_bins_wrong"}, dy, 0);
   endtask

   task automatic wait_clear(input string name);
      int g = 0;
      @(negedge clk);
      while (busy === 1'b1 && g < 400) begin
         g++;
         @(negedge clk);
      end
      check({name, "_clear_cycles"}, g, 128);
   endtask

   task automatic scan_zero(input string name);
      int nz = 0;
      for (int i = 0; i < 128; i++) begin
         tick();
         read_index_xaxis = 7'(i);
         read_index_yaxis = 7'(i);
         @(negedge clk);
         if (data_xaxis !== 16'd0 || data_yaxis !== 16'd0) nz++;
      end
      tick();
      read_index_xaxis = '0;
      read_index_yaxis = '0;
      @(negedge clk);
      check({name, "_nonzero_bins"}, nz, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = 1'b0; ev_valid = 1'b0; window_len = 32'd100;
      ev_x = '0; ev_y = '0; read_index_xaxis = '0; read_index_yaxis = '0;

      tbl[0] = '{7'd5,   7'd9,  16'd3, 16'd3};
      tbl[1] = '{7'd127, 7'd0,  16'd1, 16'd1};
      tbl[2] = '{7'd0,   7'd5,  16'd0, 16'd0};
      tbl[3] = '{7'd6,   7'd10, 16'd0, 16'd0};
      tbl[4] = '{7'd4,   7'd8,  16'd0, 16'd0};
      tbl[5] = '{7'd126, 7'd1,  16'd0, 16'd0};

      // Reset state
      do_reset();
      check("rst_start", start_sending, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frame_count, 0);
      check("rst_overruns", overrun_count, 0);
      check("rst_data", {data_xaxis, data_yaxis}, 0);

      // Single events, window of 100
      window_len = 32'd100;
      tick();
      enable = 1'b1;
      send_ev(7'd5, 7'd9);
      send_ev(7'd5, 7'd9);
      send_ev(7'd5, 7'd9);
      send_ev(7'd127, 7'd0);
      repeat (95) tick();
      @(negedge clk);
      check("t1_start_before_end", start_sending, 0);
      tick();
      @(negedge clk);
      check("t1_start_at_end", start_sending, 1);
      check("t1_frames", frame_count, 1);
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         read_index_xaxis = tbl[i].rx;
         read_index_yaxis = tbl[i].ry;
         @(negedge clk);
         check($sformatf("tbl%0d_x", i), data_xaxis, tbl[i].ex);
         check($sformatf("tbl%0d_y", i), data_yaxis, tbl[i].ey);
      end
      tick();
      read_index_xaxis = '0;
      read_index_yaxis = '0;
      @(negedge clk);
      clear_exp();
      exp_x[5] = 16'd3; exp_x[127] = 16'd1; exp_y[9] = 16'd3; exp_y[0] = 16'd1;
      capture_frame("t1");
      compare_frame("t1");
      wait_clear("t1");
      scan_zero("t1_cleared");
      check("t1_overruns", overrun_count, 0);

      // Event on the window-end cycle belongs to the next frame
      do_reset();
      window_len = 32'd100;
      tick();
      enable = 1'b1;
      send_ev(7'd3, 7'd3);
      repeat (98) tick();
      send_ev(7'd7, 7'd7);
      enable = 1'b0;
      @(negedge clk);
      check("swap_busy", busy, 1);
      check("swap_frames", frame_count, 1);
      clear_exp();
      exp_x[3] = 16'd1; exp_y[3] = 16'd1;
      capture_frame("swap_f1");
      compare_frame("swap_f1");
      wait_clear("swap_f1");
      scan_zero("swap_cleared");
      tick();
      enable = 1'b1;
      repeat (100) tick();
      enable = 1'b0;
      @(negedge clk);
      check("swap_frames2", frame_count, 2);
      clear_exp();
      exp_x[7] = 16'd1; exp_y[7] = 16'd1;
      capture_frame("swap_f2");
      compare_frame("swap_f2");
      wait_clear("swap_f2");

      // Overrun while readout is held in R_ARM
      do_reset();
      window_len = 32'd50;
      tick();
      enable = 1'b1;
      send_ev(7'd1, 7'd1);
      repeat (49) tick();
      @(negedge clk);
      check("ovr_frames_a", frame_count, 1);
      check("ovr_count_a", overrun_count, 0);
      send_ev(7'd2, 7'd2);
      repeat (49) tick();
      @(negedge clk);
      check("ovr_count_b", overrun_count, 1);
      send_ev(7'd2, 7'd2);
      repeat (49) tick();
      @(negedge clk);
      check("ovr_count_c", overrun_count, 2);
      check("ovr_frames_c", frame_count, 1);
      enable = 1'b0;
      clear_exp();
      exp_x[1] = 16'd1; exp_y[1] = 16'd1;
      capture_frame("ovr_f1");
      compare_frame("ovr_f1");
      wait_clear("ovr_f1");
      tick();
      enable = 1'b1;
      repeat (50) tick();
      enable = 1'b0;
      @(negedge clk);
      check("ovr_frames_d", frame_count, 2);
      clear_exp();
      exp_x[2] = 16'd2; exp_y[2] = 16'd2;
      capture_frame("ovr_f2");
      compare_frame("ovr_f2");
      wait_clear("ovr_f2");

      // Controller slow to start: ARM timeout gaps
      do_reset();
      window_len = 32'd100;
      tick();
      enable = 1'b1;
      send_ev(7'd10, 7'd20);
      send_ev(7'd10, 7'd20);
      @(negedge clk);
      wait_start("busy", 200);
      enable = 1'b0;
      begin
         int bad = 0;
         int lows = 0;
         logic exp_hi;
         for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            exp_hi = !(c == 1024 || c == 1025 || c == 2050 || c == 2051);
            if (start_sending !== exp_hi) bad++;
            if (start_sending !== 1'b1) lows++;
         end
         check("busy_gap_pattern", bad, 0);
         check("busy_low_cycles", lows, 4);
      end
      clear_exp();
      exp_x[10] = 16'd2; exp_y[20] = 16'd2;
      capture_frame("busy");
      compare_frame("busy");
      wait_clear("busy");
      begin
         int hi = 0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (start_sending !== 1'b0) hi++;
         end
         check("busy_no_resend", hi, 0);
      end
      check("busy_frames", frame_count, 1);

      // Reset in R_RUN at read_index 60
      do_reset();
      window_len = 32'd100;
      tick();
      enable = 1'b1;
      send_ev(7'd4, 7'd4);
      @(negedge clk);
      wait_start("rrun", 200);
      enable = 1'b0;
      for (int i = 127; i > 60; i--) begin
         tick();
         read_index_xaxis = 7'(i);
         read_index_yaxis = 7'(i);
      end
      tick();
      read_index_xaxis = 7'd60;
      read_index_yaxis = 7'd60;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read_index_xaxis = '0;
      read_index_yaxis = '0;
      @(negedge clk);
      check("rrun_start", start_sending, 0);
      check("rrun_busy", busy, 0);
      check("rrun_frames", frame_count, 0);
      check("rrun_overruns", overrun_count, 0);
      scan_zero("rrun_banks");

      // Count limit at x=0
      do_reset();
      window_len = 32'd70001;
      tick();
      enable = 1'b1;
      ev_x = 7'd0; ev_y = 7'd1; ev_valid = 1'b1;
      repeat (70000) tick();
      ev_valid = 1'b0;
      tick();
      enable = 1'b0;
      @(negedge clk);
      check("sat_start", start_sending, 1);
      tick();
      read_index_xaxis = 7'd0;
      read_index_yaxis = 7'd1;
      @(negedge clk);
      check("sat_x0", data_xaxis, SAT_EXP);
      check("sat_y1", data_yaxis, SAT_EXP);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
